// File: rtl/midi_msg_parser_if.sv
// Byte-in / note-event-out bundle for midi_msg_parser.
// master: byte source and event consumer (receiver glue / synth side).
// slave:  the parser itself.
interface midi_msg_parser_if #(
  parameter int unsigned FIFO_AW = 2
) ();

  logic [7:0]       new_byte;
  logic             new_byte_ready;
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_on;
  logic [6:0]       evt_note;
  logic [6:0]       evt_velocity;
  logic             overflow;
  logic [FIFO_AW:0] fifo_level;

  modport master (
    output new_byte,
    output new_byte_ready,
    output evt_ready,
    input  evt_valid,
    input  evt_on,
    input  evt_note,
    input  evt_velocity,
    input  overflow,
    input  fifo_level
  );

  modport slave (
    input  new_byte,
    input  new_byte_ready,
    input  evt_ready,
    output evt_valid,
    output evt_on,
    output evt_note,
    output evt_velocity,
    output overflow,
    output fifo_level
  );

endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: decodes Note On/Off for one channel (or all, with OMNI)
// and queues the events in a first-word-fall-through FIFO with valid/ready output.
// Realtime bytes are transparent; SysEx, system-common and other channel-voice
// messages are skipped.
// Build option: define MIDI_RUNNING_STATUS_EN to keep running status across
// completed messages; otherwise every message needs its own status byte.
module midi_msg_parser #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0,
  parameter int unsigned FIFO_AW = 2
) (
  input logic               clk,
  input logic               reset_n,
  midi_msg_parser_if.slave  bus
);

  localparam int unsigned DEPTH    = 2 ** FIFO_AW;
  localparam logic [3:0]  CHAN_NIB = 4'(CHANNEL);

  typedef enum logic [1:0] {
    StIdle,
    StD1,
    StD2,
    StSysex
  } state_e;

  state_e           r_state;
  logic             r_rs_valid;
  logic [7:0]       r_rs_byte;
  logic [6:0]       r_d1;

  logic [14:0]      r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic             r_overflow;

  logic [7:0]       w_byte;
  logic             w_is_data;
  logic             w_take_d1;
  logic             w_take_d2;
  logic             w_note_msg;
  logic             w_chan_ok;
  logic             w_push;
  logic [14:0]      w_push_data;
  logic [FIFO_AW:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic [14:0]      w_head;

  assign w_byte = bus.new_byte;

  // Classify the strobed byte and decide whether it completes a note event.
  always_comb begin
    w_is_data   = bus.new_byte_ready & ~w_byte[7];
    // A data byte in IDLE with running status acts as the first data byte.
    w_take_d1   = w_is_data & ((r_state == StD1) | ((r_state == StIdle) & r_rs_valid));
    w_take_d2   = w_is_data & (r_state == StD2);
    w_note_msg  = (r_rs_byte[7:5] == 3'b100);
    w_chan_ok   = OMNI | (r_rs_byte[3:0] == CHAN_NIB);
    w_push      = w_take_d2 & w_note_msg & w_chan_ok;
    // Note On with zero velocity is reported as Note Off; velocity passes through.
    w_push_data = {r_rs_byte[4] & (w_byte[6:0] != 7'd0), r_d1, w_byte[6:0]};
  end

  // Parser FSM: status tracking, running status and first data byte capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_rs_valid <= 1'b0;
      r_rs_byte  <= 8'h00;
      r_d1       <= 7'h00;
    end else if (bus.new_byte_ready) begin
      if (w_byte >= 8'hF8) begin
        // Realtime: leave everything untouched.
        r_state <= r_state;
      end else if (w_byte == 8'hF0) begin
        r_state    <= StSysex;
        r_rs_valid <= 1'b0;
      end else if (w_byte[7:4] == 4'hF) begin
        r_state    <= StIdle;
        r_rs_valid <= 1'b0;
      end else if (w_byte[7]) begin
        // New channel status; also aborts any partial message.
        r_state    <= StD1;
        r_rs_valid <= 1'b1;
        r_rs_byte  <= w_byte;
      end else if (w_take_d1) begin
        r_d1 <= w_byte[6:0];
        // Program change / channel pressure carry a single data byte.
        if (r_rs_byte[7:5] == 3'b110) begin
          r_state <= StIdle;
`ifndef MIDI_RUNNING_STATUS_EN
          r_rs_valid <= 1'b0;
`endif
        end else begin
          r_state <= StD2;
        end
      end else if (w_take_d2) begin
        r_state <= StIdle;
`ifndef MIDI_RUNNING_STATUS_EN
        r_rs_valid <= 1'b0;
`endif
      end
    end
  end

  // FIFO bookkeeping; pointers carry one extra bit so full and empty differ.
  always_comb begin
    w_level = r_wr_ptr - r_rd_ptr;
    w_empty = (w_level == '0);
    w_full  = (w_level == (FIFO_AW + 1)'(DEPTH));
    w_pop   = ~w_empty & bus.evt_ready;
    // Full is fine if the head leaves in the same cycle.
    w_wr_en = w_push & (~w_full | w_pop);
    w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  end

  // Pointer and sticky overflow update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push & ~w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Event storage; contents are don't-care until written, outputs are gated when empty.
  always_ff @(posedge clk) begin
    if (reset_n && w_wr_en) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_data;
    end
  end

  assign bus.evt_valid    = ~w_empty;
  assign bus.evt_on       = w_empty ? 1'b0 : w_head[14];
  assign bus.evt_note     = w_empty ? 7'd0 : w_head[13:7];
  assign bus.evt_velocity = w_empty ? 7'd0 : w_head[6:0];
  assign bus.overflow     = r_overflow;
  assign bus.fifo_level   = w_level;

endmodule
